r_exec_pipe: RTL and testbench
==============================

R_EXEC_PIPE -- requirements
Module: r_exec_pipe

Interface
REQ-001 Parameters: none; the block SHALL be fixed at 32-bit data and a 32-entry register file.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr  in  32  R-type word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
REQ-006 instr_ready  out  1  block can accept an instruction this cycle.
REQ-007 wb_valid  out  1  writeback result present.
REQ-008 wb_ready  in  1  consumer accepts writeback.
REQ-009 wb_addr  out  5  destination register of the result.
REQ-010 wb_data  out  32  result value.
REQ-011 illegal  out  1  one-cycle pulse for a rejected instruction.
REQ-012 dbg_addr  in  5  debug read address; dbg_data  out  32  combinational register-file read, 0 for address 0.

Function
REQ-013 Accept SHALL occur on an edge where instr_valid && instr_ready; instr_ready = !(wb_valid && !wb_ready).
REQ-014 Stages SHALL be: ID/EX register loaded at accept with decoded fields and operands; EX/WB register loaded on the next edge with the result; register file written on the edge where wb_valid && wb_ready.
REQ-015 Latency: an instruction accepted at edge N SHALL present wb_valid in the cycle after edge N+1; with no stall, throughput SHALL be one instruction per cycle.
REQ-016 Supported funct values with opcode 0: 100000 add, 100010 sub, 000010 srl (rt >> shamt), 000000 sll (rt << shamt), 100100 and, 100101 or.
REQ-017 add and sub SHALL wrap modulo 2^32, with no overflow flag or trap; shifts are logical and shift in zeros.
REQ-018 Operand forwarding priority SHALL be the ID/EX result (youngest), then EX/WB, then the register file; back-to-back dependent instructions SHALL see correct values with no bubble.
REQ-019 Register 0 SHALL always read 0; a write to rd=0 SHALL pulse wb_valid with wb_addr=0 and SHALL leave the file unchanged, and that result SHALL NOT be forwarded.
REQ-020 Stall: while wb_valid && !wb_ready, all stage registers SHALL hold, wb_addr and wb_data SHALL stay stable, and the file SHALL NOT be written.
REQ-021 An opcode other than 0, or an unsupported funct, SHALL still be accepted; illegal SHALL be high for exactly one cycle after the accept edge; the instruction SHALL produce no writeback and no forwarding.
REQ-022 dbg_data SHALL reflect committed file contents only, never in-flight results.

Reset
REQ-023 When rst_n=0 at an edge, the block SHALL clear all stage valids and set wb_valid=0, wb_addr=0, wb_data=0, illegal=0.
REQ-024 Reset SHALL load each register k with the value k (r0=0, r7=7, r31=31).
REQ-025 Reset mid-operation SHALL discard in-flight instructions with no writeback; instr_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-026 With R_EXEC_SLT_EN defined, funct 101010 (slt, signed) and 101011 (sltu) SHALL produce 1 or 0 in bit 0 with upper bits zero.
REQ-027 With R_EXEC_SLT_EN undefined, funct 101010 and 101011 SHALL be treated as illegal per REQ-021.

Verification
REQ-028 Reset, then dbg_addr=13 -> dbg_data=13; add rd=1 rs=0 rt=1 -> wb_valid two cycles after accept, wb_addr=1, wb_data=1.
REQ-029 sub rd=9 rs=7 rt=3, then back-to-back add rd=10 rs=9 rt=11 -> wb_data 4, then 15 on consecutive cycles (forwarding path).
REQ-030 srl rd=5 rt=8 shamt=2 -> 2; sub rd=6 rs=0 rt=1 -> 0xFFFFFFFF (wrap).
REQ-031 Hold wb_ready=0 for 3 cycles while wb_valid -> wb_data stable, instr_ready=0, no instruction lost, file updated once.
REQ-032 opcode 0x08 -> illegal pulse, no wb_valid; slt rd=2 rs=3 rt=7 -> 1 with R_EXEC_SLT_EN, illegal without; add rd=0 -> r0 still reads 0.
REQ-033 Assert rst_n=0 with 2 instructions in flight -> no wb_valid after reset, dbg_data for addr 9 reads 9.

Source files
------------

// File: rtl/r_exec_pipe.sv
// Two-stage R-type execute pipe (ID/EX, EX/WB) with forwarding, writeback handshake and debug read port.
// Optional feature: define R_EXEC_SLT_EN to enable slt/sltu.
module r_exec_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    logic [31:0] rf_q [32];

    logic        idex_vld_q;
    logic [4:0]  idex_rd_q, idex_sh_q;
    logic [5:0]  idex_fn_q;
    logic [31:0] idex_a_q, idex_b_q;

    logic        wbv_q, ill_q;
    logic [4:0]  wba_q;
    logic [31:0] wbd_q;

    logic        stall, acc, legal_d;
    logic [31:0] exres_d, op_a_d, op_b_d;

    wire [5:0] opc = instr[31:26];
    wire [4:0] rs  = instr[25:21];
    wire [4:0] rt  = instr[20:16];
    wire [4:0] rd  = instr[15:11];
    wire [4:0] sh  = instr[10:6];
    wire [5:0] fn  = instr[5:0];

    assign stall       = wbv_q && !wb_ready;
    assign instr_ready = !stall;
    assign acc         = instr_valid && instr_ready;
    assign wb_valid    = wbv_q;
    assign wb_addr     = wba_q;
    assign wb_data     = wbd_q;
    assign illegal     = ill_q;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

    always_comb begin
        legal_d = 1'b0;
        if (opc == 6'd0) begin
            case (fn)
                F_ADD, F_SUB, F_SRL, F_SLL, F_AND, F_OR: legal_d = 1'b1;
`ifdef R_EXEC_SLT_EN
                F_SLT, F_SLTU:                           legal_d = 1'b1;
`endif
                default:                                 legal_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        exres_d = 32'd0;
        case (idex_fn_q)
            F_ADD:   exres_d = idex_a_q + idex_b_q;
            F_SUB:   exres_d = idex_a_q - idex_b_q;
            F_SRL:   exres_d = idex_b_q >> idex_sh_q;
            F_SLL:   exres_d = idex_b_q << idex_sh_q;
            F_AND:   exres_d = idex_a_q & idex_b_q;
            F_OR:    exres_d = idex_a_q | idex_b_q;
`ifdef R_EXEC_SLT_EN
            F_SLT:   exres_d = {31'd0, $signed(idex_a_q) < $signed(idex_b_q)};
            F_SLTU:  exres_d = {31'd0, idex_a_q < idex_b_q};
`endif
            default: exres_d = 32'd0;
        endcase
    end

    // Youngest producer wins; rd=0 results never match since r0 is short-circuited.
    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 5'd0)                      return 32'd0;
        else if (idex_vld_q && idex_rd_q == r) return exres_d;
        else if (wbv_q && wba_q == r)       return wbd_q;
        else                                return rf_q[r];
    endfunction

    always_comb begin
        op_a_d = fwd(rs);
        op_b_d = fwd(rt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_vld_q <= 1'b0;
            wbv_q      <= 1'b0;
            wba_q      <= 5'd0;
            wbd_q      <= 32'd0;
            ill_q      <= 1'b0;
            for (int k = 0; k < 32; k++) rf_q[k] <= 32'(k);
        end else begin
            ill_q <= acc && !legal_d;
            if (wbv_q && wb_ready && wba_q != 5'd0) rf_q[wba_q] <= wbd_q;
            if (!stall) begin
                idex_vld_q <= acc && legal_d;
                if (acc) begin
                    idex_rd_q <= rd;
                    idex_sh_q <= sh;
                    idex_fn_q <= fn;
                    idex_a_q  <= op_a_d;
                    idex_b_q  <= op_b_d;
                end
                wbv_q <= idex_vld_q;
                if (idex_vld_q) begin
                    wba_q <= idex_rd_q;
                    wbd_q <= exres_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_r_exec_pipe.sv
// Self-checking bench for r_exec_pipe: directed steps plus random traffic against a program-order model.
module tb_r_exec_pipe;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        instr_valid = 0;
    logic [31:0] instr = 0;
    logic        instr_ready;
    logic        wb_valid;
    logic        wb_ready = 1;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = 0;
    logic [31:0] dbg_data;

    r_exec_pipe dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] addr; logic [31:0] data; int vis; } wbent_t;
    wbent_t      q[$];
    logic [31:0] mreg [32];   // architectural state in program order
    logic [31:0] creg [32];   // committed state
    int          cyc = 0;
    int          ncmp = 0;
    int          nerr = 0;
    logic        exp_ill = 0;
    logic        last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                       input int rd, input int sh, input int fn);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic is_legal(input logic [31:0] w);
        if (w[31:26] != 0) return 0;
        case (w[5:0])
            6'd32, 6'd34, 6'd2, 6'd0, 6'd36, 6'd37: return 1;
`ifdef R_EXEC_SLT_EN
            6'd42, 6'd43: return 1;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (fn)
            6'd32: return a + b;
            6'd34: return a - b;
            6'd2:  return b >> sh;
            6'd0:  return b << sh;
            6'd36: return a & b;
            6'd37: return a | b;
            6'd42: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd43: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_init();
        q.delete();
        for (int k = 0; k < 32; k++) begin
            mreg[k] = 32'(k);
            creg[k] = 32'(k);
        end
        exp_ill = 0;
    endtask

    // One clock: check outputs at the negedge, advance the model, step past the posedge.
    task automatic cycle();
        logic exp_wbv, acc;
        logic [31:0] res;
        wbent_t e;
        @(negedge clk);
        exp_wbv = (q.size() > 0) && (q[0].vis <= cyc);
        chk("wb_valid", wb_valid, exp_wbv);
        chk("instr_ready", instr_ready, !(exp_wbv && !wb_ready));
        chk("illegal", illegal, exp_ill);
        chk("dbg_data", dbg_data, (dbg_addr == 0) ? 32'd0 : creg[dbg_addr]);
        if (exp_wbv) begin
            chk("wb_addr", 32'(wb_addr), 32'(q[0].addr));
            chk("wb_data", wb_data, q[0].data);
        end
        acc = instr_valid && !(exp_wbv && !wb_ready);
        if (exp_wbv && wb_ready) begin
            if (q[0].addr != 0) creg[q[0].addr] = q[0].data;
            void'(q.pop_front());
        end
        exp_ill = 0;
        if (acc) begin
            if (!is_legal(instr)) exp_ill = 1;
            else begin
                res = ref_alu(instr[5:0], mreg[instr[25:21]], mreg[instr[20:16]], instr[10:6]);
                e.addr = instr[15:11];
                e.data = res;
                e.vis  = cyc + 2;
                q.push_back(e);
                if (e.addr != 0) mreg[e.addr] = res;
            end
        end
        last_acc = acc;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        instr_valid = 1;
        instr = w;
        last_acc = 0;
        for (int t = 0; t < 20 && !last_acc; t++) cycle();
        chk("accept", 32'(last_acc), 32'd1);
        instr_valid = 0;
    endtask

    task automatic drain();
        instr_valid = 0;
        wb_ready = 1;
        for (int t = 0; t < 20 && q.size() > 0; t++) cycle();
        chk("drain", 32'(q.size()), 32'd0);
        cycle();
    endtask

    task automatic dbg_expect(input string tag, input int a, input logic [31:0] v);
        dbg_addr = a[4:0];
        #1;
        chk(tag, dbg_data, v);
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        instr_valid = 0;
        wb_ready = 1;
        repeat (n) @(posedge clk);
        #1;
        model_init();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst_n = 1;
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fl [9];
        logic [31:0] w;
        fl = '{6'd32, 6'd34, 6'd2, 6'd0, 6'd36, 6'd37, 6'd42, 6'd43, 6'd7};
        do_reset(2);
        dbg_expect("dbg_r13", 13, 32'd13);
        dbg_expect("dbg_r0", 0, 32'd0);

        issue(mk(0, 0, 1, 1, 0, 32));
        drain();
        dbg_expect("add_r1", 1, 32'd1);

        issue(mk(0, 7, 3, 9, 0, 34));
        issue(mk(0, 9, 11, 10, 0, 32));
        drain();
        dbg_expect("fwd_r9", 9, 32'd4);
        dbg_expect("fwd_r10", 10, 32'd15);

        issue(mk(0, 0, 8, 5, 2, 2));
        issue(mk(0, 0, 1, 6, 0, 34));
        drain();
        dbg_expect("srl_r5", 5, 32'd2);
        dbg_expect("sub_wrap_r6", 6, 32'hFFFF_FFFF);

        issue(mk(0, 12, 1, 12, 0, 32));
        issue(mk(0, 12, 12, 12, 0, 32));
        instr_valid = 1;
        instr = mk(0, 12, 0, 13, 0, 37);
        wb_ready = 0;
        dbg_addr = 12;
        repeat (3) cycle();
        wb_ready = 1;
        last_acc = 0;
        for (int t = 0; t < 10 && !last_acc; t++) cycle();
        chk("stall_accept", 32'(last_acc), 32'd1);
        drain();
        dbg_expect("stall_r12", 12, 32'd26);
        dbg_expect("stall_r13", 13, 32'd26);

        issue(mk(8, 1, 2, 3, 0, 32));
        drain();
        issue(mk(0, 3, 7, 2, 0, 42));
        drain();
`ifdef R_EXEC_SLT_EN
        dbg_expect("slt_r2", 2, 32'd1);
`else
        dbg_expect("slt_r2", 2, 32'd2);
`endif
        issue(mk(0, 5, 6, 0, 0, 32));
        drain();
        dbg_expect("r0_zero", 0, 32'd0);

        for (int i = 0; i < 500; i++) begin
            w = mk(($urandom % 8 == 0) ? int'($urandom % 64) : 0,
                   $urandom % 8, $urandom % 8, $urandom % 8, $urandom % 32, 0);
            w[5:0] = fl[$urandom % 9];
            instr_valid = ($urandom % 4) != 0;
            instr = w;
            wb_ready = ($urandom % 4) != 0;
            dbg_addr = 5'($urandom % 8);
            cycle();
        end
        drain();

        issue(mk(0, 1, 1, 9, 0, 32));
        issue(mk(0, 9, 9, 9, 0, 32));
        do_reset(1);
        dbg_addr = 9;
        repeat (4) cycle();
        dbg_expect("flush_r9", 9, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
